// File: rtl/bsg_clk_div_ctrl_pkg.sv
// Shared types for the bsg_clk_div_ctrl divider: the configuration-port state encoding.
package bsg_clk_div_ctrl_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_e;

endpackage

// File: rtl/bsg_clk_div_ctrl_ctr.sv
// Clearable up-counter that wraps to zero when it reaches a programmable terminal count.
module bsg_clk_div_ctrl_ctr #(
  parameter int ctr_width_p = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   clear,
  input  logic [ctr_width_p-1:0] limit,
  output logic [ctr_width_p-1:0] cnt,
  output logic                   tc
);

  assign tc = (cnt == limit);

  // Wrapping on tc keeps cnt <= limit, so the width can never overflow.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt <= '0;
    end else if (clear || tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bsg_clk_div_ctrl.sv
// Glitch-free programmable clock divider feeding bsg_clkbuf; period = 2*(div+1) clk_i cycles.
// Optional clock gating via en_i when BSG_CLK_DIV_CTRL_GATE_EN is defined.
module bsg_clk_div_ctrl
  import bsg_clk_div_ctrl_pkg::*;
#(
  parameter int ctr_width_p = 8,
  parameter int reset_div_p = 0
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
`ifdef BSG_CLK_DIV_CTRL_GATE_EN
  input  logic                   en_i,
`endif
  input  logic                   v_i,
  input  logic [ctr_width_p-1:0] div_i,
  output logic                   ready_o,
  output logic [ctr_width_p-1:0] div_o,
  output logic                   clk_o,
  output logic                   tick_o
);

  logic [ctr_width_p-1:0] cnt_r;
  logic [ctr_width_p-1:0] div_r;
  logic [ctr_width_p-1:0] pend_r;
  state_e                 state_r;
  logic                   tc;
  logic                   run_en;
  logic                   ctr_clear;
  logic                   toggle;
  logic                   apply;

`ifdef BSG_CLK_DIV_CTRL_GATE_EN
  assign run_en = en_i;
`else
  assign run_en = 1'b1;
`endif

  // While gated, a high phase is allowed to finish; only the low phase is frozen at cnt=0.
  assign ctr_clear = ~run_en & ~clk_o;
  assign toggle    = tc & (clk_o | run_en);

  // New divisor lands on the falling boundary, or at once if the output is already parked low.
  assign apply = (state_r == PEND) & ((tc & clk_o) | ctr_clear);

  bsg_clk_div_ctrl_ctr #(
    .ctr_width_p(ctr_width_p)
  ) ctr (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clear  (ctr_clear),
    .limit  (div_r),
    .cnt    (cnt_r),
    .tc     (tc)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      clk_o   <= 1'b0;
      div_r   <= ctr_width_p'(reset_div_p);
      pend_r  <= '0;
      state_r <= RUN;
    end else begin
      if (toggle) begin
        clk_o <= ~clk_o;
      end
      case (state_r)
        RUN: begin
          if (v_i) begin
            pend_r  <= div_i;
            state_r <= PEND;
          end
        end
        PEND: begin
          if (apply) begin
            div_r   <= pend_r;
            state_r <= RUN;
          end
        end
        default: state_r <= RUN;
      endcase
    end
  end

  assign ready_o = (state_r == RUN);
  assign div_o   = div_r;
  assign tick_o  = (cnt_r == div_r) & ~clk_o & run_en & ~reset_i;

endmodule

// File: tb/tb_bsg_clk_div_ctrl.sv
// Directed self-checking bench for bsg_clk_div_ctrl (default build, reset_div_p = 0).
module tb_bsg_clk_div_ctrl;

  localparam int W = 8;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic         v_i;
  logic [W-1:0] div_i;
  logic         ready_o;
  logic [W-1:0] div_o;
  logic         clk_o;
  logic         tick_o;
`ifdef BSG_CLK_DIV_CTRL_GATE_EN
  logic         en_i = 1'b1;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk_i = ~clk_i;

  bsg_clk_div_ctrl #(
    .ctr_width_p(W),
    .reset_div_p(0)
  ) dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
`ifdef BSG_CLK_DIV_CTRL_GATE_EN
    .en_i   (en_i),
`endif
    .v_i    (v_i),
    .div_i  (div_i),
    .ready_o(ready_o),
    .div_o  (div_o),
    .clk_o  (clk_o),
    .tick_o (tick_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clk_i cycle and check clk_o / tick_o on the falling edge.
  task automatic cyc(input logic eclk, input logic etick, input string tag);
    @(negedge clk_i);
    chk({tag, "_clk"}, {31'd0, clk_o}, {31'd0, eclk});
    chk({tag, "_tick"}, {31'd0, tick_o}, {31'd0, etick});
  endtask

  // Expected patterns are written MSB first in time order.
  task automatic seq(input int n, input logic [31:0] ec, input logic [31:0] et, input string tag);
    for (int i = 0; i < n; i++) begin
      cyc(ec[n-1-i], et[n-1-i], $sformatf("%s%0d", tag, i));
    end
  endtask

  task automatic accept_note(input logic [W-1:0] d);
    $display("tb: presenting divisor %0d (ready_o=%0b)", d, ready_o);
  endtask

  initial begin
    reset_i = 1'b1;
    v_i     = 1'b0;
    div_i   = '0;
    repeat (2) @(negedge clk_i);
    chk("rst_clk",   {31'd0, clk_o},   32'd0);
    chk("rst_tick",  {31'd0, tick_o},  32'd0);
    chk("rst_ready", {31'd0, ready_o}, 32'd1);
    chk("rst_div",   {24'd0, div_o},   32'd0);

    // Divide by 2 out of reset.
    reset_i = 1'b0;
    #1;
    chk("rel_tick", {31'd0, tick_o}, 32'd1);
    chk("rel_clk",  {31'd0, clk_o},  32'd0);
    seq(4, 32'b1010, 32'b0101, "d0_");

    // Accept 3; applied at the very next falling boundary.
    v_i = 1'b1; div_i = 8'd3; accept_note(div_i);
    cyc(1'b1, 1'b0, "acc3");
    chk("acc3_ready", {31'd0, ready_o}, 32'd0);
    chk("acc3_div",   {24'd0, div_o},   32'd0);
    v_i = 1'b0;
    cyc(1'b0, 1'b0, "app3");
    chk("app3_div",   {24'd0, div_o},   32'd3);
    chk("app3_ready", {31'd0, ready_o}, 32'd1);
    seq(11, 32'b000_1111_0000, 32'b001_0000_0001, "d3_");

    // Switch to 2.
    v_i = 1'b1; div_i = 8'd2; accept_note(div_i);
    cyc(1'b1, 1'b0, "acc2");
    chk("acc2_ready", {31'd0, ready_o}, 32'd0);
    v_i = 1'b0;
    seq(4, 32'b1110, 32'b0000, "app2_");
    chk("app2_div",   {24'd0, div_o},   32'd2);
    chk("app2_ready", {31'd0, ready_o}, 32'd1);
    seq(5, 32'b00111, 32'b01000, "d2_");

    // Boundary-cycle accept of 5: one more full old period first.
    v_i = 1'b1; div_i = 8'd5; accept_note(div_i);
    cyc(1'b0, 1'b0, "bnd5");
    chk("bnd5_ready", {31'd0, ready_o}, 32'd0);
    chk("bnd5_div",   {24'd0, div_o},   32'd2);
    // Offer 7 throughout PEND; it must be ignored.
    div_i = 8'd7; accept_note(div_i);
    seq(5, 32'b00111, 32'b01000, "old2_");
    chk("pend_ready", {31'd0, ready_o}, 32'd1 - 32'd1);
    v_i = 1'b0;
    cyc(1'b0, 1'b0, "app5");
    chk("app5_div",   {24'd0, div_o},   32'd5);
    chk("app5_ready", {31'd0, ready_o}, 32'd1);
    seq(12, 32'b0000_0111_1110, 32'b0000_1000_0000, "d5_");

    // Queue 9, then reset asynchronously mid high phase.
    seq(5, 32'b00000, 32'b00001, "d5lo_");
    v_i = 1'b1; div_i = 8'd9; accept_note(div_i);
    cyc(1'b1, 1'b0, "acc9");
    chk("acc9_ready", {31'd0, ready_o}, 32'd0);
    v_i = 1'b0;
    cyc(1'b1, 1'b0, "hi9");
    #2;
    reset_i = 1'b1;
    #1;
    chk("arst_clk",   {31'd0, clk_o},   32'd0);
    chk("arst_tick",  {31'd0, tick_o},  32'd0);
    chk("arst_div",   {24'd0, div_o},   32'd0);
    chk("arst_ready", {31'd0, ready_o}, 32'd1);
    @(negedge clk_i);
    chk("arst_hold_clk", {31'd0, clk_o}, 32'd0);
    reset_i = 1'b0;
    #1;
    chk("post_tick", {31'd0, tick_o}, 32'd1);
    seq(4, 32'b1010, 32'b0101, "post_");
    chk("post_div",   {24'd0, div_o},   32'd0);
    chk("post_ready", {31'd0, ready_o}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
